hc_sr04_emulator: RTL and testbench

Synthesizable HC-SR04 ultrasonic sensor model. It is the responder on the trig/echo interface that the hc_sr04 controller drives.
- Detects and validates a trig pulse.
- Waits a fixed burst delay.
- Returns an echo pulse whose width encodes a programmable distance.
- Used for hardware-in-loop and board bring-up of the sensor acquisition path without a physical sensor.

---
 rtl/hc_sr04_emulator.sv | 155 +++++++++++++++
 tb/tb_hc_sr04_emulator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hc_sr04_emulator.sv
// Purpose: HC-SR04 ultrasonic sensor stand-in that answers a validated trig pulse with a distance-encoded echo.
// Latency: echo rises BURST_DELAY+1 cycles after the synchronized trig fall and stays high for the computed width.
// Backpressure: none; trig edges outside IDLE/TRIG_HI are ignored, and en=0 aborts to IDLE on the next cycle.
module hc_sr04_emulator #(
  parameter int unsigned TRIG_MIN       = 120,
  parameter int unsigned BURST_DELAY    = 2400,
  parameter int unsigned CYCLES_PER_CM  = 696,
  parameter int unsigned MAX_CM         = 400,
  parameter int unsigned TIMEOUT_CYCLES = 456000,
  parameter int unsigned HOLDOFF        = 12000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        trig,
  input  logic [15:0] distance_cm,
  output logic        echo,
  output logic        busy,
  output logic        trig_err,
  output logic [2:0]  state,
  output logic [7:0]  meas_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG_HI = 3'd1,
    ST_BURST   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  localparam logic [31:0] TRIG_MIN_W = 32'(TRIG_MIN);
  localparam logic [31:0] BURST_W    = 32'(BURST_DELAY);
  localparam logic [31:0] CPCM_W     = 32'(CYCLES_PER_CM);
  localparam logic [31:0] MAX_CM_W   = 32'(MAX_CM);
  localparam logic [31:0] TIMEOUT_W  = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] HOLDOFF_W  = 32'(HOLDOFF);

  state_t      state_q;
  logic [31:0] cnt;
  logic [31:0] echo_width;
  logic [15:0] dist_lat;
  logic        trig_s1;
  logic        trig_s2;
  logic        trig_d;
  logic [1:0]  sync_fill;
  logic        armed;
  logic        trig_rise;
  logic        trig_fall;

  // Two-flop synchronizer, edge-detect history, and arming so a trig held high
  // across reset release or enable assertion must drop low before it can start a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_d    <= 1'b0;
      sync_fill <= 2'd0;
      armed     <= 1'b0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
      if (sync_fill != 2'd3) sync_fill <= sync_fill + 2'd1;
      armed <= en && (sync_fill == 2'd3) && (armed || !trig_d);
    end
  end

  assign trig_rise = trig_s2 & ~trig_d & armed;
  assign trig_fall = ~trig_s2 & trig_d;

  // Echo width from the latched distance; zero or out-of-range targets report the timeout width.
  always_comb begin
    echo_width = 32'(dist_lat) * CPCM_W;
    if ((dist_lat == 16'd0) || (32'(dist_lat) > MAX_CM_W)) echo_width = TIMEOUT_W;
  end

  // Main sequencer: one shared counter times the trig width, burst delay, echo and holdoff.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt        <= '0;
      dist_lat   <= '0;
      echo       <= 1'b0;
      trig_err   <= 1'b0;
      meas_count <= '0;
    end else begin
      trig_err <= 1'b0;
      if (!en) begin
        state_q <= ST_IDLE;
        cnt     <= '0;
        echo    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (trig_rise) begin
              state_q <= ST_TRIG_HI;
              cnt     <= 32'd1;
            end
          end
          ST_TRIG_HI: begin
            if (trig_fall) begin
              cnt <= '0;
              if (cnt >= TRIG_MIN_W) begin
                dist_lat <= distance_cm;
                state_q  <= ST_BURST;
              end else begin
                trig_err <= 1'b1;
                state_q  <= ST_IDLE;
              end
            end else if (trig_s2 && (cnt < TRIG_MIN_W)) begin
              cnt <= cnt + 32'd1;
            end
          end
          ST_BURST: begin
            if (cnt == BURST_W - 32'd1) begin
              cnt     <= '0;
              echo    <= 1'b1;
              state_q <= ST_ECHO;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          ST_ECHO: begin
            if (cnt == echo_width - 32'd1) begin
              cnt        <= '0;
              echo       <= 1'b0;
              meas_count <= meas_count + 8'd1;
              state_q    <= ST_HOLDOFF;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          ST_HOLDOFF: begin
            if (cnt == HOLDOFF_W - 32'd1) begin
              cnt     <= '0;
              state_q <= ST_IDLE;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          default: begin
            cnt     <= '0;
            echo    <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_hc_sr04_emulator.sv
// Purpose: directed bench for hc_sr04_emulator with scaled-down timing parameters.
// Latency: expected echo rise is 3+BURST_DELAY clocks after trig is dropped (2 sync + 1 fall cycle).
// Backpressure: not applicable; every wait on the DUT is bounded.
module tb_hc_sr04_emulator;

  localparam int TRIG_MIN = 8;
  localparam int BURST    = 20;
  localparam int CPCM     = 6;
  localparam int MAXCM    = 40;
  localparam int TIMEOUT  = 500;
  localparam int HOLD     = 30;
  localparam int BOUND    = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        trig = 1'b0;
  logic [15:0] distance_cm = 16'd10;
  logic        echo;
  logic        busy;
  logic        trig_err;
  logic [2:0]  state;
  logic [7:0]  meas_count;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  int echo_rises = 0;

  hc_sr04_emulator #(
    .TRIG_MIN(TRIG_MIN), .BURST_DELAY(BURST), .CYCLES_PER_CM(CPCM),
    .MAX_CM(MAXCM), .TIMEOUT_CYCLES(TIMEOUT), .HOLDOFF(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .trig(trig), .distance_cm(distance_cm),
    .echo(echo), .busy(busy), .trig_err(trig_err), .state(state), .meas_count(meas_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (trig_err === 1'b1) err_pulses++;
  always @(posedge echo) echo_rises++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds trig high for n clock periods and returns at the drop.
  task automatic pulse(input int n);
    trig = 1'b1;
    repeat (n) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic run_echo(input int n, output int dly, output int wid);
    pulse(n);
    dly = 0;
    while (echo !== 1'b1 && dly < BOUND) begin @(negedge clk); dly++; end
    wid = 0;
    while (echo === 1'b1 && wid < BOUND) begin @(negedge clk); wid++; end
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (state !== 3'd0 && k < BOUND) begin @(negedge clk); k++; end
  endtask

  initial begin
    int dly, wid, k, e0, r0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_echo", 32'(echo), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(trig_err), 0);
    check("rst_state", 32'(state), 0);
    check("rst_meas", 32'(meas_count), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // nominal 10 cm echo
    e0 = err_pulses;
    run_echo(10, dly, wid);
    check("d10_delay", dly, 3 + BURST);
    check("d10_width", wid, 10 * CPCM);
    check("d10_meas", 32'(meas_count), 1);
    check("d10_hold_state", 32'(state), 4);
    check("d10_hold_busy", 32'(busy), 1);
    wait_idle(k);
    check("d10_holdoff", k, HOLD);
    check("d10_noerr", err_pulses - e0, 0);

    // short trig pulses, including one cycle below the minimum
    e0 = err_pulses; r0 = echo_rises;
    @(negedge clk); pulse(5);
    repeat (6) @(negedge clk);
    check("short5_err", err_pulses - e0, 1);
    check("short5_state", 32'(state), 0);
    e0 = err_pulses;
    pulse(TRIG_MIN - 1);
    repeat (6) @(negedge clk);
    check("short7_err", err_pulses - e0, 1);
    check("short_noecho", echo_rises - r0, 0);
    check("short_meas", 32'(meas_count), 1);

    // exactly the minimum width is accepted
    distance_cm = 16'd1; e0 = err_pulses;
    run_echo(TRIG_MIN, dly, wid);
    check("min_width", wid, CPCM);
    check("min_noerr", err_pulses - e0, 0);
    wait_idle(k);

    // timeout and range boundary
    distance_cm = 16'd0;
    run_echo(30, dly, wid); check("d0_width", wid, TIMEOUT); wait_idle(k);
    distance_cm = 16'd41;
    run_echo(30, dly, wid); check("d41_width", wid, TIMEOUT); wait_idle(k);
    distance_cm = 16'd40;
    run_echo(30, dly, wid); check("d40_width", wid, 40 * CPCM); wait_idle(k);
    check("range_meas", 32'(meas_count), 5);

    // distance change and retrigger during ECHO, trig pulse during HOLDOFF
    distance_cm = 16'd20; r0 = echo_rises; e0 = err_pulses;
    pulse(10);
    dly = 0;
    while (echo !== 1'b1 && dly < BOUND) begin @(negedge clk); dly++; end
    distance_cm = 16'd5;
    wid = 0;
    while (echo === 1'b1 && wid < BOUND) begin
      if (wid == 20) trig = 1'b1;
      if (wid == 30) trig = 1'b0;
      @(negedge clk); wid++;
    end
    check("d20_width", wid, 20 * CPCM);
    k = 0;
    while (state !== 3'd0 && k < BOUND) begin
      if (k == 5) trig = 1'b1;
      if (k == 15) trig = 1'b0;
      @(negedge clk); k++;
    end
    repeat (40) @(negedge clk);
    check("retrig_rises", echo_rises - r0, 1);
    check("retrig_err", err_pulses - e0, 0);
    check("retrig_state", 32'(state), 0);
    check("retrig_meas", 32'(meas_count), 6);

    // async reset mid-ECHO, trig held high across release
    distance_cm = 16'd10;
    pulse(10);
    dly = 0;
    while (echo !== 1'b1 && dly < BOUND) begin @(negedge clk); dly++; end
    repeat (10) @(negedge clk);
    rst = 1'b0; trig = 1'b1;
    #1;
    check("arst_echo", 32'(echo), 0);
    check("arst_state", 32'(state), 0);
    check("arst_meas", 32'(meas_count), 0);
    @(negedge clk); rst = 1'b1; r0 = echo_rises;
    repeat (30) @(negedge clk);
    check("held_state", 32'(state), 0);
    check("held_noecho", echo_rises - r0, 0);
    trig = 1'b0;
    repeat (5) @(negedge clk);
    run_echo(10, dly, wid);
    check("post_rst_delay", dly, 3 + BURST);
    check("post_rst_width", wid, 10 * CPCM);
    wait_idle(k);

    // en=0 mid-ECHO, re-enable with trig held high
    pulse(10);
    dly = 0;
    while (echo !== 1'b1 && dly < BOUND) begin @(negedge clk); dly++; end
    repeat (5) @(negedge clk);
    en = 1'b0; trig = 1'b1;
    @(negedge clk);
    check("dis_state", 32'(state), 0);
    check("dis_echo", 32'(echo), 0);
    check("dis_meas", 32'(meas_count), 1);
    repeat (3) @(negedge clk);
    en = 1'b1; r0 = echo_rises;
    repeat (30) @(negedge clk);
    check("en_held_state", 32'(state), 0);
    check("en_held_noecho", echo_rises - r0, 0);
    trig = 1'b0;
    repeat (5) @(negedge clk);
    run_echo(10, dly, wid);
    check("post_en_width", wid, 10 * CPCM);
    wait_idle(k);
    check("post_en_meas", 32'(meas_count), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
